// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative multiply/divide unit that holds the MIPS HI/LO registers.
// MULT, MULTU, DIV and DIVU each take 33 cycles from the start edge to the result:
// 32 single-bit iterations, then one fix-up/write-back cycle.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high; returns to IDLE with HI/LO cleared
//   start  - begin operation `op` on a/b (accepted only in IDLE)
//   op     - 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b   - rs / rt operands
//   mthi   - write wdata to HI (idle only)
//   mtlo   - write wdata to LO (idle only)
//   wdata  - data for MTHI/MTLO
//   busy   - operation in progress (registered)
//   done   - one-cycle pulse when new HI/LO first become visible (registered)
//   hi, lo - architectural HI/LO registers
module mips_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  op_reg, op_next;
    logic [31:0] mag_a_reg, mag_a_next;   // multiplicand / dividend bits still to consume
    logic [31:0] mag_b_reg, mag_b_next;   // multiplier bits still to consume / divisor
    logic        sign_reg, sign_next;     // sign of product or quotient
    logic        dsign_reg, dsign_next;   // dividend negative (signed divide only)
    logic        bzero_reg, bzero_next;
    logic [31:0] raw_a_reg, raw_a_next;   // unmodified dividend, returned in HI on divide by zero
    logic [63:0] acc_reg, acc_next;       // product, or {remainder, quotient}
    logic [4:0]  cnt_reg, cnt_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;

    // Operand preparation for a new operation.
    logic        op_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    // Iteration datapath.
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [31:0] div_rem;
    logic        div_qbit;

    // Fix-up datapath.
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    always_comb begin
        op_signed = op[0];
        abs_a     = (op_signed && a[31]) ? (~a + 32'd1) : a;
        abs_b     = (op_signed && b[31]) ? (~b + 32'd1) : b;
    end

    // Right-shifting shift-add multiply: the partial product is added to the upper
    // half, then the whole 64-bit accumulator shifts right by one. After 32 steps
    // the accumulator holds the full unsigned product.
    always_comb begin
        mul_sum = {1'b0, acc_reg[63:32]} + (mag_b_reg[0] ? {1'b0, mag_a_reg} : 33'd0);
    end

    // Restoring divide: bring the next dividend bit (MSB of mag_a_reg) into the
    // remainder and trial-subtract the divisor. The quotient fills acc[31:0] from
    // the right. The remainder is always below the divisor, so 32 bits suffice.
    always_comb begin
        div_shift = {acc_reg[63:32], mag_a_reg[31]};
        div_diff  = div_shift - {1'b0, mag_b_reg};
        div_qbit  = ~div_diff[32];
        div_rem   = div_qbit ? div_diff[31:0] : div_shift[31:0];
    end

    always_comb begin
        prod_fix = sign_reg  ? (~acc_reg + 64'd1)               : acc_reg;
        quot_fix = sign_reg  ? (~acc_reg[31:0] + 32'd1)         : acc_reg[31:0];
        rem_fix  = dsign_reg ? (~acc_reg[63:32] + 32'd1)        : acc_reg[63:32];
    end

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        mag_a_next = mag_a_reg;
        mag_b_next = mag_b_reg;
        sign_next  = sign_reg;
        dsign_next = dsign_reg;
        bzero_next = bzero_reg;
        raw_a_next = raw_a_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    op_next    = op;
                    mag_a_next = abs_a;
                    mag_b_next = abs_b;
                    sign_next  = op_signed & (a[31] ^ b[31]);
                    // Remainder follows the dividend sign only for signed divide.
                    dsign_next = op_signed & a[31];
                    bzero_next = (b == 32'd0);
                    raw_a_next = a;
                    acc_next   = 64'd0;
                    cnt_next   = 5'd0;
                    state_next = RUN;
                end else begin
                    if (mthi) hi_next = wdata;
                    if (mtlo) lo_next = wdata;
                end
            end

            RUN: begin
                if (op_reg[1]) begin
                    acc_next   = {div_rem, acc_reg[30:0], div_qbit};
                    mag_a_next = {mag_a_reg[30:0], 1'b0};
                end else begin
                    acc_next   = {mul_sum, acc_reg[31:1]};
                    mag_b_next = {1'b0, mag_b_reg[31:1]};
                end
                cnt_next = cnt_reg + 5'd1;
                if (cnt_reg == 5'd31) state_next = FIX;
            end

            FIX: begin
                if (!op_reg[1]) begin
                    hi_next = prod_fix[63:32];
                    lo_next = prod_fix[31:0];
                end else if (bzero_reg) begin
                    hi_next = raw_a_reg;
                    lo_next = 32'hFFFF_FFFF;
                end else begin
                    // 0x8000_0000 / -1 falls out naturally: magnitude quotient
                    // 0x8000_0000 with a positive result sign.
                    hi_next = rem_fix;
                    lo_next = quot_fix;
                end
                state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
        done_next = (state_reg == FIX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            op_reg    <= 2'd0;
            mag_a_reg <= 32'd0;
            mag_b_reg <= 32'd0;
            sign_reg  <= 1'b0;
            dsign_reg <= 1'b0;
            bzero_reg <= 1'b0;
            raw_a_reg <= 32'd0;
            acc_reg   <= 64'd0;
            cnt_reg   <= 5'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            mag_a_reg <= mag_a_next;
            mag_b_reg <= mag_b_next;
            sign_reg  <= sign_next;
            dsign_reg <= dsign_next;
            bzero_reg <= bzero_next;
            raw_a_reg <= raw_a_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv: a table of directed operations with
// hand-computed HI/LO, plus hand-written sequences for MTHI/MTLO, ignored
// start/strobes while busy, back-to-back start on done, and mid-run reset.
module tb_mips_muldiv;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int pass_cnt = 0;
    int total_cnt = 0;

    localparam logic [1:0] MULTU = 2'b00;
    localparam logic [1:0] MULT  = 2'b01;
    localparam logic [1:0] DIVU  = 2'b10;
    localparam logic [1:0] DIV   = 2'b11;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs [12];

    mips_muldiv dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        else
            pass_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start for exactly one edge (E0); returns at the sample after E0.
    task automatic do_start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts samples with busy high until it drops; bounded at 40 cycles.
    task automatic wait_done(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        int pulses;

        vecs[0]  = '{"multu_max",    MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{"mult_neg3x5",  MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2]  = '{"div_neg7d2",   DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{"divu_100d7",   DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        vecs[4]  = '{"div_ovf",      DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vecs[5]  = '{"divu_by0",     DIVU,  32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF};
        vecs[6]  = '{"div_by0",      DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[7]  = '{"div_7dneg2",   DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[8]  = '{"mult_neg1sq",  MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1};
        vecs[9]  = '{"multu_2p31x2", MULTU, 32'h8000_0000, 32'd2,         32'd1,         32'd0};
        vecs[10] = '{"divu_big",     DIVU,  32'hFFFF_FFFF, 32'd16,        32'd15,        32'h0FFF_FFFF};
        vecs[11] = '{"mult_6x7",     MULT,  32'd6,         32'd7,         32'd0,         32'd42};

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = 32'd0;
        b     = 32'd0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        wdata = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_hi",   {32'd0, hi}, 64'd0);
        chk("reset_lo",   {32'd0, lo}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);

        // MTHI, MTLO, then both together.
        mthi = 1'b1; wdata = 32'h1111_2222; tick(); mthi = 1'b0;
        chk("mthi_hi", {32'd0, hi}, {32'd0, 32'h1111_2222});
        chk("mthi_lo", {32'd0, lo}, 64'd0);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h3333_4444; tick(); mthi = 1'b0; mtlo = 1'b0;
        chk("mtboth_hi", {32'd0, hi}, {32'd0, 32'h3333_4444});
        chk("mtboth_lo", {32'd0, lo}, {32'd0, 32'h3333_4444});

        // Table of operations.
        for (int i = 0; i < 12; i++) begin
            do_start(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(n);
            chk({vecs[i].name, "_latency"}, 64'(n), 64'd33);
            chk({vecs[i].name, "_done"}, {63'd0, done}, 64'd1);
            chk({vecs[i].name, "_hi"}, {32'd0, hi}, {32'd0, vecs[i].exp_hi});
            chk({vecs[i].name, "_lo"}, {32'd0, lo}, {32'd0, vecs[i].exp_lo});
            tick();
            chk({vecs[i].name, "_done_1cyc"}, {63'd0, done}, 64'd0);
            $display("op=%0d a=%08h b=%08h hi=%08h lo=%08h cycles=%0d (%s)",
                     vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, n, vecs[i].name);
        end
        // hi/lo now 0 / 42.

        // start together with mthi in IDLE: start wins, HI not written at E0.
        op = MULT; a = 32'hFFFF_FFFD; b = 32'd5;
        start = 1'b1; mthi = 1'b1; wdata = 32'h5555_5555;
        tick();
        start = 1'b0; mthi = 1'b0;
        chk("startwins_busy", {63'd0, busy}, 64'd1);
        chk("startwins_hi", {32'd0, hi}, 64'd0);
        // Mid-run: start with other operands and MTHI are both ignored.
        tick(); tick(); tick();
        op = MULTU; a = 32'd1000; b = 32'd1000; start = 1'b1;
        mthi = 1'b1; wdata = 32'hDEAD_BEEF;
        tick();
        start = 1'b0; mthi = 1'b0;
        chk("run_hi_hold", {32'd0, hi}, 64'd0);
        chk("run_lo_hold", {32'd0, lo}, 64'd42);
        wait_done(n);
        chk("ign_latency", 64'(n + 4), 64'd33);
        chk("ign_hi", {32'd0, hi}, {32'd0, 32'hFFFF_FFFF});
        chk("ign_lo", {32'd0, lo}, {32'd0, 32'hFFFF_FFF1});
        $display("ignored start/mthi during MULT: hi=%08h lo=%08h", hi, lo);
        tick();
        chk("after_ign_busy", {63'd0, busy}, 64'd0);
        mtlo = 1'b1; wdata = 32'hCAFE_F00D; tick(); mtlo = 1'b0;
        chk("mtlo_lo", {32'd0, lo}, {32'd0, 32'hCAFE_F00D});
        chk("mtlo_hi", {32'd0, hi}, {32'd0, 32'hFFFF_FFFF});

        // Back-to-back: new start accepted in the cycle done is high.
        do_start(DIVU, 32'd100, 32'd7);
        wait_done(n);
        chk("b2b_first_done", {63'd0, done}, 64'd1);
        do_start(MULTU, 32'd3, 32'd4);
        chk("b2b_busy", {63'd0, busy}, 64'd1);
        wait_done(n);
        chk("b2b_latency", 64'(n), 64'd33);
        chk("b2b_lo", {32'd0, lo}, 64'd12);
        chk("b2b_hi", {32'd0, hi}, 64'd0);
        $display("back-to-back MULTU 3*4: hi=%08h lo=%08h", hi, lo);
        tick();

        // Reset at iteration 10 of a DIVU.
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h7777_7777; tick(); mthi = 1'b0; mtlo = 1'b0;
        do_start(DIVU, 32'd1000, 32'd3);
        repeat (10) tick();
        chk("prereset_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        chk("midreset_hi", {32'd0, hi}, 64'd0);
        chk("midreset_lo", {32'd0, lo}, 64'd0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) pulses++;
            tick();
        end
        chk("midreset_no_done", 64'(pulses), 64'd0);
        do_start(MULTU, 32'd6, 32'd7);
        wait_done(n);
        chk("postreset_latency", 64'(n), 64'd33);
        chk("postreset_lo", {32'd0, lo}, 64'd42);
        chk("postreset_hi", {32'd0, hi}, 64'd0);
        $display("after mid-run reset, MULTU 6*7: hi=%08h lo=%08h", hi, lo);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mips_muldiv.md
# mips_muldiv

Iterative multiply/divide unit holding the architectural HI/LO registers of the MIPS CPU. It sits in the execute stage beside the ALU and takes the same rs/rt operands. It runs MULT, MULTU, DIV and DIVU as 32-iteration shift-add and restoring-divide sequences. The controller stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO; MTHI/MTLO write through the `mthi`/`mtlo` strobes.

## Interface
- No parameters; datapath fixed at 32 bits, iteration count fixed at 32.
- `clk` in 1: rising-edge clock.
- `reset` in 1: reset, synchronous, active-high.
- `start` in 1: begin operation `op` on `a`/`b`; accepted only in IDLE.
- `op` in 2: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a` in 32: rs operand (multiplicand / dividend).
- `b` in 32: rt operand (multiplier / divisor).
- `mthi` in 1: write `wdata` to HI (MTHI).
- `mtlo` in 1: write `wdata` to LO (MTLO).
- `wdata` in 32: MTHI/MTLO data.
- `busy` out 1: operation in progress; controller stalls MFHI/MFLO/MULT/DIV while high.
- `done` out 1: one-cycle pulse in the cycle HI/LO first show a new result.
- `hi` out 32: HI register; remainder for divides, upper product for multiplies.
- `lo` out 32: LO register; quotient for divides, lower product for multiplies.

## Operation
- States: IDLE, RUN, FIX.
- IDLE with `start`=1:
  - Latch `op`.
  - Latch magnitudes of `a` and `b`: two's-complement absolute value for signed ops, raw for unsigned.
  - Latch the result sign: `a[31]^b[31]` for signed, 0 for unsigned. Also latch the dividend sign `a[31]`.
  - Clear the 64-bit accumulator and the 5-bit iteration counter. Go to RUN.
- RUN multiply: one shift-add step per cycle, LSB-first, on the 64-bit product.
- RUN divide: one restoring step per cycle. Shift the remainder/quotient pair left, trial-subtract the divisor, set the quotient bit if the result is non-negative.
- RUN: counter increments each cycle; after the 32nd iteration go to FIX.
- FIX multiply: if the sign is set, negate the full 64-bit product (two's complement across HI:LO). HI=product[63:32], LO=product[31:0].
- FIX divide:
  - LO = quotient, negated if the result sign is set.
  - HI = remainder, negated if the dividend was negative; remainder takes the sign of the dividend.
- FIX divide by zero (`b`=0 latched): HI=`a` (raw), LO=32'hFFFF_FFFF, for both DIV and DIVU. Latency is unchanged.
- FIX signed overflow: DIV 0x8000_0000 / 0xFFFF_FFFF gives LO=0x8000_0000, HI=0.
- FIX: write HI/LO, assert `done`, return to IDLE.
- `start` while not IDLE: ignored; no queueing.
- `mthi`/`mtlo` in IDLE without `start`: write `wdata` at the next edge. Both strobes asserted together write both registers.
- `mthi`/`mtlo` while busy: ignored.
- `start` together with `mthi`/`mtlo` in IDLE: `start` wins and the strobes are ignored.
- `hi`/`lo` hold their old values throughout RUN.
- `reset`: state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, counter=0. Reset mid-operation discards the operation; HI/LO are zeroed, not partially updated.

## Timing
- Edge E0 samples `start`; `busy`=1 from the cycle after E0.
- Edges E1..E32 perform the 32 iterations; the state is FIX after E32.
- Edge E33 writes HI/LO; after E33 `busy`=0, `done`=1 for exactly one cycle, and new `hi`/`lo` are visible.
- Fixed latency: 33 cycles from start edge to result, identical for all ops and for divide by zero.
- A new `start` is accepted in the same cycle `done`=1, since the state is already IDLE.
- MTHI/MTLO latency: 1 edge.
- `busy` and `done` are registered outputs; no combinational path from inputs to outputs.

## Test plan
- MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF -> after 33 cycles `done` pulses once; HI=0xFFFF_FFFE, LO=0x0000_0001; `busy` high for exactly 33 cycles.
- MULT a=0xFFFF_FFFD (-3), b=5 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFF1. Then DIV a=0xFFFF_FFF9 (-7), b=2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
- DIVU a=100, b=7 -> LO=14, HI=2. Then DIV a=0x8000_0000, b=0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
- DIVU a=0x1234_5678, b=0 -> HI=0x1234_5678, LO=0xFFFF_FFFF, same 33-cycle latency.
- During a MULT run:
  - Pulse `start` with different operands and `mthi` with `wdata`=0xDEAD_BEEF -> both ignored; the result matches the original operands.
  - After `done`, `mtlo` with 0xCAFE_F00D -> LO=0xCAFE_F00D one edge later, HI unchanged.
- Assert `reset` at iteration 10 of a DIVU -> next cycle `busy`=0, `hi`=`lo`=0, no `done` pulse. A following MULTU 6*7 gives LO=42, HI=0.
